// File: rtl/dyt_sram_req_ctrl.sv
// Request/response front end for a single-port SRAM: one op per cycle, credit-limited
// reads tracked through the SRAM read latency into an in-order response FIFO.
module dyt_sram_req_ctrl #(
  parameter int DATA_W       = 32,
  parameter int SRAM_ADDR_W  = 6,
  parameter int READ_LATENCY = 2,
  parameter int RESP_DEPTH   = 4,
  parameter int ID_W         = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic                              req_we_i,
  input  logic [31:0]                       req_addr_i,
  input  logic [DATA_W-1:0]                 req_wdata_i,
  input  logic [DATA_W/8-1:0]               req_be_i,
  input  logic [ID_W-1:0]                   req_id_i,
  output logic                              resp_valid_o,
  input  logic                              resp_ready_i,
  output logic [DATA_W-1:0]                 resp_rdata_o,
  output logic [ID_W-1:0]                   resp_id_o,
  output logic [$clog2(RESP_DEPTH+1)-1:0]   outstanding_o,
  output logic [SRAM_ADDR_W-1:0]            sram_address_o,
  output logic [DATA_W-1:0]                 sram_w_data_o,
  output logic [DATA_W/8-1:0]               sram_wen_o,
  output logic                              sram_ren_o,
  input  logic [DATA_W-1:0]                 sram_r_data_i
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RESP_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RESP_DEPTH);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } resp_t;

  logic                    acc, rd_acc, push, pop;
  logic [CNT_W-1:0]        out_q, out_d, cnt_q, cnt_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [READ_LATENCY-1:0] pipe_vld_q;
  logic [ID_W-1:0]         pipe_id_q [READ_LATENCY];
  resp_t                   fifo_q [RESP_DEPTH];

  // Writes never need a credit; a read needs a free FIFO slot reserved up front.
  assign req_ready_o = !rst && (req_we_i || (out_q < DEPTH_C));
  assign acc         = req_valid_i && req_ready_o;
  assign rd_acc      = acc && !req_we_i;

  assign sram_address_o = acc ? req_addr_i[SRAM_ADDR_W+1:2] : '0;
  assign sram_w_data_o  = req_wdata_i;
  assign sram_wen_o     = (acc && req_we_i) ? req_be_i : '0;

  // The output-register enable leads the FIFO push by one cycle so the wrapper's
  // final register holds the word in the push cycle.
  generate
    if (READ_LATENCY == 1) begin : g_ren_acc
      assign sram_ren_o = rd_acc;
    end else begin : g_ren_pipe
      assign sram_ren_o = pipe_vld_q[READ_LATENCY-2];
    end
  endgenerate

  assign push          = pipe_vld_q[READ_LATENCY-1];
  assign resp_valid_o  = (cnt_q != '0);
  assign pop           = resp_valid_o && resp_ready_i;
  assign resp_rdata_o  = resp_valid_o ? fifo_q[rd_ptr_q].data : '0;
  assign resp_id_o     = resp_valid_o ? fifo_q[rd_ptr_q].id : '0;
  assign outstanding_o = out_q;

  // NOTE: every next-state variable gets a default first so no latch is inferred.
  always_comb begin
    out_d    = out_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (rd_acc && !pop)      out_d = out_q + CNT_W'(1);
    else if (!rd_acc && pop) out_d = out_q - CNT_W'(1);
    if (push && !pop)        cnt_d = cnt_q + CNT_W'(1);
    else if (!push && pop)   cnt_d = cnt_q - CNT_W'(1);
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
  end

  // NOTE: non-blocking assignments so each pipeline stage takes its predecessor's pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pipe_vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_id_q[i] <= '0;
    end else begin
      out_q        <= out_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pipe_vld_q[0] <= rd_acc;
      pipe_id_q[0]  <= req_id_i;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_id_q[i]  <= pipe_id_q[i-1];
      end
    end
  end

  // NOTE: FIFO storage has no reset; the head outputs are masked to 0 while it is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{id: pipe_id_q[READ_LATENCY-1], data: sram_r_data_i};
  end

endmodule
